buffer_sched: RTL and testbench

BUFFER_SCHED -- requirements
Module: buffer_sched

---
 rtl/buffer_sched_if.sv | 35 +++
 rtl/buffer_sched.sv | 110 +++++++++++
 tb/tb_buffer_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_sched_if.sv
// Buffer scheduler bus: producer write port, consumer pair-read port, buffer command port.
// Latency: none; signal bundle only.
// Backpressure: wr_ready / rd_gnt carry grants back to producer and consumer.
interface buffer_sched_if #(
    parameter int AW = 14
);
    logic          wr_valid;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_gnt;
    logic          rd_valid;
    logic [63:0]   rd_data;
    logic [1:0]    buf_state;
    logic [31:0]   buf_data_in;
    logic [AW-1:0] buf_addr;
    logic [63:0]   buf_data_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    // Environment side: producer, consumer and the buffer memory.
    modport master (
        output wr_valid, wr_data, rd_req, buf_data_out,
        input  wr_ready, rd_gnt, rd_valid, rd_data, buf_state, buf_data_in,
               buf_addr, count, full, empty
    );

    // Scheduler side.
    modport slave (
        input  wr_valid, wr_data, rd_req, buf_data_out,
        output wr_ready, rd_gnt, rd_valid, rd_data, buf_state, buf_data_in,
               buf_addr, count, full, empty
    );
endinterface

// File: rtl/buffer_sched.sv
// Arbitrates single-word writes and 64-bit pair reads onto one word buffer; BUF_SCHED_WRITE_PRIO_EN makes writes always win.
// Latency: grants are combinational; rd_valid/rd_data follow one cycle after rd_gnt.
// Backpressure: wr_ready low when full or read wins; rd_gnt low below two words or when write wins.
module buffer_sched #(
    parameter int DEPTH = 128,
    parameter int AW    = 14
) (
    input  logic            clk,
    input  logic            rst,
    buffer_sched_if.slave   bus
);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] TWO     = (AW+1)'(2);

    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_valid_q;
    logic [63:0]   rd_data_q;

    logic wr_elig;
    logic rd_elig;
    logic wr_win;
    logic rd_win;

    assign wr_elig = bus.wr_valid && (cnt < DEPTH_C);
    assign rd_elig = bus.rd_req && (cnt >= TWO);

`ifdef BUF_SCHED_WRITE_PRIO_EN
    assign wr_win = wr_elig;
    assign rd_win = rd_elig && !wr_elig;
`else
    // High when the most recent contended cycle went to the reader.
    logic last_rd;

    assign wr_win = wr_elig && (!rd_elig || last_rd);
    assign rd_win = rd_elig && (!wr_elig || !last_rd);

    // Remember the winner of each contended cycle so the loser goes first next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd <= 1'b1;
        end else if (wr_elig && rd_elig) begin
            last_rd <= rd_win;
        end
    end
`endif

    // Grants are suppressed while reset is held so nothing touches the buffer.
    assign bus.wr_ready    = wr_win && !rst;
    assign bus.rd_gnt      = rd_win && !rst;
    assign bus.buf_state   = bus.wr_ready ? 2'b01 : (bus.rd_gnt ? 2'b10 : 2'b00);
    assign bus.buf_data_in = bus.wr_data;
    assign bus.buf_addr    = AW'(wr_ptr);

    // A read issued just before reset must not surface as rd_valid during reset.
    assign bus.rd_valid = rd_valid_q && !rst;
    assign bus.rd_data  = bus.rd_valid ? bus.buf_data_out : rd_data_q;

    assign bus.count = cnt;
    assign bus.full  = (cnt == DEPTH_C);
    assign bus.empty = (cnt == '0);

    // Occupancy moves by +1 per write grant and -2 per read grant.
    always_comb begin
        cnt_nxt = cnt;
        if (bus.wr_ready) begin
            cnt_nxt = cnt + ONE;
        end else if (bus.rd_gnt) begin
            cnt_nxt = cnt - TWO;
        end
    end

    // Occupancy and pointers; pointer width equals log2(DEPTH) so they wrap for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (bus.wr_ready) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (bus.rd_gnt) begin
                rd_ptr <= rd_ptr + PW'(2);
            end
        end
    end

    // Read return: flag one cycle after the grant, hold the last pair in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_gnt;
            if (rd_valid_q) begin
                rd_data_q <= bus.buf_data_out;
            end
        end
    end

    // The pointer gap must always match occupancy modulo DEPTH.
    assert property (@(posedge clk) disable iff (rst)
        PW'(wr_ptr - rd_ptr) == cnt[PW-1:0]);
endmodule

// File: tb/tb_buffer_sched.sv
// Randomized scoreboard bench for buffer_sched with a queue-based reference model.
module tb_buffer_sched;
    localparam int DEPTH = 128;
    localparam int AW    = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buffer_sched_if #(.AW(AW)) bus();

    buffer_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] d;
        int          g;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] q[$];
    int          wp;
    bit          lg_rd;
    logic [63:0] last_rd = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // External buffer memory: store on 01, pair read on 10 returned next cycle.
    logic [31:0] mem [DEPTH];
    int          brd;
    always @(posedge clk) begin
        if (rst) begin
            brd = 0;
            bus.buf_data_out <= '0;
        end else begin
            if (bus.buf_state == 2'b01)
                mem[int'(bus.buf_addr) % DEPTH] = bus.buf_data_in;
            if (bus.buf_state == 2'b10) begin
                bus.buf_data_out <= {mem[brd], mem[(brd + 1) % DEPTH]};
                brd = (brd + 2) % DEPTH;
            end
        end
    end

    task automatic model_reset();
        q.delete();
        sb.delete();
        wp    = 0;
        lg_rd = 1'b1;
    endtask

    // One cycle of stimulus: drive at negedge, compare, update model, return after posedge.
    task automatic step(input bit wv, input logic [31:0] wd, input bit rr, output int g);
        bit we, re, gw, gr;
        @(negedge clk);
        rst          = 1'b0;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_req   = rr;
        #1;
        we = wv && (q.size() < DEPTH);
        re = rr && (q.size() >= 2);
        if (we && re) begin
`ifdef BUF_SCHED_WRITE_PRIO_EN
            gw = 1'b1;
`else
            gw    = lg_rd;
            lg_rd = !lg_rd;
`endif
            gr = !gw;
        end else begin
            gw = we;
            gr = re;
        end
        chk("wr_ready", 64'(bus.wr_ready), 64'(gw));
        chk("rd_gnt", 64'(bus.rd_gnt), 64'(gr));
        chk("buf_state", 64'(bus.buf_state), gw ? 64'd1 : (gr ? 64'd2 : 64'd0));
        chk("buf_data_in", 64'(bus.buf_data_in), 64'(wd));
        chk("buf_addr", 64'(bus.buf_addr), 64'(wp));
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("full", 64'(bus.full), 64'(q.size() == DEPTH));
        chk("empty", 64'(bus.empty), 64'(q.size() == 0));
        if (gw) begin
            q.push_back(wd);
            wp = (wp + 1) % DEPTH;
        end
        if (gr) begin
            exp_t e;
            e.d = {q[0], q[1]};
            e.g = cyc;
            sb.push_back(e);
            void'(q.pop_front());
            void'(q.pop_front());
        end
        g = gw ? 1 : (gr ? 2 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst          = 1'b1;
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_data  = $urandom;
            bus.rd_req   = 1'($urandom_range(0, 1));
            model_reset();
            #1;
            chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
            chk("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
            chk("rst_buf_state", 64'(bus.buf_state), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_buf_addr", 64'(bus.buf_addr), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever rd_valid shows, checks hold otherwise.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            chk("rd_valid_in_reset", 64'(bus.rd_valid), 64'd0);
            last_rd = '0;
        end else begin
            while (sb.size() > 0 && sb[0].g < cyc - 1) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_missing actual=0 required=1 (grant cycle %0d)", sb[0].g);
                void'(sb.pop_front());
            end
            if (bus.rd_valid) begin
                if (sb.size() == 0 || sb[0].g != cyc - 1) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_valid_unexpected actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    chk("rd_data", bus.rd_data, sb[0].d);
                    void'(sb.pop_front());
                end
                last_rd = bus.rd_data;
            end else begin
                chk("rd_data_hold", bus.rd_data, last_rd);
            end
        end
    end

    initial begin
        int          g;
        logic [7:0]  pat;
        bit          hold;
        bit          wv, rr;
        int          bias;

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        model_reset();

        // Two writes then a pair read.
        do_reset(2);
        step(1'b1, 32'h11, 1'b0, g);
        step(1'b1, 32'h22, 1'b0, g);
        chk("count_after_two_writes", 64'(bus.count), 64'd2);
        step(1'b0, 32'h0, 1'b1, g);
        chk("pair_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("pair_rd_data", bus.rd_data, 64'h0000001100000022);
        chk("count_after_pair", 64'(bus.count), 64'd0);
        step(1'b0, 32'h0, 1'b0, g);

        // Contention from count=4.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, g);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, 1'b1, g);
            pat = {pat[5:0], 2'(g)};
        end
`ifdef BUF_SCHED_WRITE_PRIO_EN
        chk("contention_pattern", 64'(pat), 64'h55);
        chk("contention_count", 64'(bus.count), 64'd8);
`else
        chk("contention_pattern", 64'(pat), 64'h66);
        chk("contention_count", 64'(bus.count), 64'd2);
`endif

        // Fill to capacity, try one more write, drain.
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, g);
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_addr_wrap", 64'(bus.buf_addr), 64'd0);
        step(1'b1, $urandom, 1'b0, g);
        chk("full_write_blocked", 64'(bus.count), 64'(DEPTH));
        for (int i = 0; i < DEPTH / 2; i++) step(1'b0, 32'h0, 1'b1, g);
        chk("drain_empty", 64'(bus.empty), 64'd1);

        // Single word cannot be read; reset right after a grant kills rd_valid.
        do_reset(1);
        step(1'b1, 32'hA, 1'b0, g);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, g);
            chk("one_word_no_read", 64'(bus.count), 64'd1);
        end
        step(1'b1, 32'hB, 1'b1, g);
        chk("second_word_count", 64'(bus.count), 64'd2);
        step(1'b0, 32'h0, 1'b1, g);
        do_reset(2);
        chk("count_after_reset_read", 64'(bus.count), 64'd0);

        // Randomized traffic with shifting write/read bias and occasional reset.
        hold = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bias = (i / 500) % 4;
            wv   = ($urandom_range(0, 4) < bias + 1);
            rr   = hold ? 1'b1 : ($urandom_range(0, 4) < 4 - bias);
            step(wv, $urandom, rr, g);
            hold = rr && (g != 2);
            if (i % 997 == 996) begin
                do_reset(1);
                hold = 1'b0;
            end
        end

        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, g);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
